apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS wait cycles before forced completion (used only with APB_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port PCLK  input  1  clock.
REQ-003 SHALL have port PRESET  input  1  reset, asynchronous, active-high; clock PCLK.
REQ-004 SHALL have port transfer  input  1  single-cycle request pulse from CPU.
REQ-005 SHALL have port write  input  1  request direction (1 = write).
REQ-006 SHALL have port addr  input  32  request byte address.
REQ-007 SHALL have port wdata  input  32  request write data.
REQ-008 SHALL have port rdata  output  32  read data, valid while ready=1.
REQ-009 SHALL have port ready  output  1  one-cycle completion strobe.
REQ-010 SHALL have port err  output  1  completion error flag, valid while ready=1.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have ports PADDR  output  32, PWRITE  output  1, PENABLE  output  1, PWDATA  output  32.
REQ-013 SHALL have port PSEL  output  5  one-hot slave select: bit0 RAM, bit1 GPO, bit2 GPI, bit3 GPIO, bit4 FND.
REQ-014 SHALL have ports PRDATA0..PRDATA4  input  32 and PREADY0..PREADY4  input  1, one pair per slave.

Function
REQ-015 SHALL decode on the latched addr[31:12]: 0x10000 RAM, 0x10001 GPO, 0x10002 GPI, 0x10003 GPIO, 0x10004 FND; any other value is unmapped.
REQ-016 SHALL implement states IDLE, SETUP, ACCESS.
REQ-017 In IDLE with transfer=1, SHALL latch addr, wdata, write into internal registers and move to SETUP next cycle; transfer outside IDLE SHALL be ignored.
REQ-018 SETUP: PSEL = decoded one-hot, PENABLE=0; unconditionally moves to ACCESS.
REQ-019 ACCESS: PSEL held, PENABLE=1; stays until the selected slave's PREADY=1.
REQ-020 In the ACCESS cycle where the selected PREADY=1, ready=1, err=0, and rdata=selected PRDATA (combinational) SHALL be driven; next state IDLE.
REQ-021 PADDR, PWRITE, PWDATA SHALL come from the latched registers and stay stable from SETUP through the end of ACCESS.
REQ-022 Unmapped address: PSEL=0 in SETUP/ACCESS; first ACCESS cycle completes with ready=1, err=1, rdata=0.
REQ-023 Outside the completion cycle, ready=0, err=0, rdata=0.
REQ-024 Minimum latency: transfer cycle T, SETUP T+1, ACCESS T+2, earliest ready T+2; next request accepted at T+3.
REQ-025 PREADY/PRDATA of non-selected slaves SHALL be ignored.

Reset
REQ-026 PRESET=1 SHALL force IDLE immediately, abandoning any transfer in flight with no ready pulse.
REQ-027 Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, ready=0, err=0, rdata=0, busy=0, timeout counter=0.

Configuration
REQ-028 With APB_MASTER_TIMEOUT_EN defined, an 8-bit or wider counter SHALL clear on ACCESS entry and increment each ACCESS cycle without PREADY; on reaching TIMEOUT_CYCLES, complete with ready=1, err=1, rdata=0, then go to IDLE.
REQ-029 Without APB_MASTER_TIMEOUT_EN, no counter SHALL exist; ACCESS waits indefinitely; err is raised only for unmapped addresses.

Verification
REQ-030 Write addr=0x1000_4000, wdata=0x0000_04D2, FND PREADY one cycle after first PENABLE -> PSEL=5'b10000, PWRITE=1, PWDATA=0x4D2, ready at T+3, err=0.
REQ-031 Read addr=0x1000_0008, RAM PRDATA=0xCAFE_F00D, PREADY immediate -> ready at T+2, rdata=0xCAFE_F00D, PSEL=5'b00001.
REQ-032 Read addr=0x2000_0000 -> PSEL stays 0, ready at T+2, err=1, rdata=0.
REQ-033 transfer pulsed during SETUP with a different addr -> ignored; PADDR unchanged; exactly one ready.
REQ-034 PRESET pulsed in ACCESS -> PSEL=0, PENABLE=0, busy=0 the same cycle; no ready.
REQ-035 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, GPI PREADY held 0 -> ready=1, err=1 after 4 ACCESS cycles; without macro, no ready after 300 cycles.

Source files
------------

// File: rtl/apb_master.sv
// APB master bridging single-cycle CPU requests to five memory-mapped APB slaves.
// Optional ACCESS-phase timeout enabled with `define APB_MASTER_TIMEOUT_EN.

module apb_slv_lane (
    input  logic        sel,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic [31:0] rdata_g,
    output logic        ready_g
);
    assign rdata_g = sel ? prdata : '0;
    assign ready_g = sel & pready;
endmodule

module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    output logic [4:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [31:0] PRDATA4,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3,
    input  logic        PREADY4
);
    localparam int NUM_SLV = 5;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t state;
    logic   unmapped;

    logic [NUM_SLV-1:0][31:0] prdata_a;
    logic [NUM_SLV-1:0]       pready_a;
    logic [NUM_SLV-1:0][31:0] rdata_g;
    logic [NUM_SLV-1:0]       ready_g;
    logic [31:0]              sel_rdata;
    logic                     sel_ready;
    logic                     in_access;
    logic                     done;
    logic                     tmo_hit;

    assign prdata_a = {PRDATA4, PRDATA3, PRDATA2, PRDATA1, PRDATA0};
    assign pready_a = {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0};

    function automatic logic [4:0] decode(input logic [19:0] page);
        case (page)
            20'h10000: decode = 5'b00001;
            20'h10001: decode = 5'b00010;
            20'h10002: decode = 5'b00100;
            20'h10003: decode = 5'b01000;
            20'h10004: decode = 5'b10000;
            default:   decode = 5'b00000;
        endcase
    endfunction

    // Each lane masks its slave's response with its select; non-selected slaves contribute nothing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_lane
            apb_slv_lane u_lane (
                .sel     (PSEL[gi]),
                .prdata  (prdata_a[gi]),
                .pready  (pready_a[gi]),
                .rdata_g (rdata_g[gi]),
                .ready_g (ready_g[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) sel_rdata = sel_rdata | rdata_g[i];
    end

    assign sel_ready = |ready_g;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = (TW > 8) ? TW : 8;
    logic [CW-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES));
`else
    wire unused_tmo_param = (TIMEOUT_CYCLES != 0);
    assign tmo_hit = 1'b0;
`endif

    // A real PREADY wins over a simultaneous timeout, so that cycle is a clean completion.
    assign in_access = (state == ACCESS);
    assign done      = in_access & (unmapped | sel_ready | tmo_hit);
    assign ready     = done;
    assign err       = in_access & (unmapped | (tmo_hit & ~sel_ready));
    assign rdata     = (in_access & sel_ready) ? sel_rdata : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            unmapped <= 1'b0;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        PADDR    <= addr;
                        PWDATA   <= wdata;
                        PWRITE   <= write;
                        PSEL     <= decode(addr[31:12]);
                        unmapped <= (decode(addr[31:12]) == 5'b00000);
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (done) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: transaction-timeline model plus per-cycle compare.
module tb_apb_master;
    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0, write = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, PADDR, PWDATA;
    logic        ready, err, busy, PWRITE, PENABLE;
    logic [4:0]  PSEL;
    logic [4:0]  prdy;
    logic [31:0] sd [5];

    int checks = 0, errors = 0;
    int cyc = 0;

    // Model of the transaction in flight, at timeline level
    bit          act = 0;
    int          t0 = 0, m_slv = -1, m_wait = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic        m_write = 1'b0;

    // Observations of the last completion
    int          n_ready = 0, r_cyc = 0;
    logic [4:0]  r_psel;
    logic        r_err;
    logic [31:0] r_rdata, r_paddr, r_pwdata;

    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .busy(busy), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PSEL(PSEL),
        .PRDATA0(sd[0]), .PRDATA1(sd[1]), .PRDATA2(sd[2]), .PRDATA3(sd[3]), .PRDATA4(sd[4]),
        .PREADY0(prdy[0]), .PREADY1(prdy[1]), .PREADY2(prdy[2]), .PREADY3(prdy[3]),
        .PREADY4(prdy[4])
    );

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic int slave_of(input logic [31:0] a);
        case (a[31:12])
            20'h10000: return 0;
            20'h10001: return 1;
            20'h10002: return 2;
            20'h10003: return 3;
            20'h10004: return 4;
            default:   return -1;
        endcase
    endfunction

    // Number of ACCESS cycles beyond the first before completion
    function automatic int eff_wait();
        if (m_slv < 0) return 0;
`ifdef APB_MASTER_TIMEOUT_EN
        return (m_wait > TMO) ? TMO : m_wait;
`else
        return m_wait;
`endif
    endfunction

    function automatic bit timed_out();
`ifdef APB_MASTER_TIMEOUT_EN
        return (m_slv >= 0) && (m_wait > TMO);
`else
        return 1'b0;
`endif
    endfunction

    // Non-selected slaves always claim ready; the selected one after m_wait ACCESS cycles
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            prdy[i] = 1'b1;
            if (act && i == m_slv) prdy[i] = ((cyc - t0) >= 2 + m_wait);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    always @(negedge PCLK) begin : cmp
        int d, e_end;
        logic [4:0] e_psel;
        logic e_rdy, e_err;
        logic [31:0] e_rd;
        if (PRESET) begin
            chk("rst_psel", 32'(PSEL), 32'd0);
            chk("rst_penable", 32'(PENABLE), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_paddr", PADDR, 32'd0);
            chk("rst_pwdata", PWDATA, 32'd0);
            chk("rst_pwrite", 32'(PWRITE), 32'd0);
        end else if (!act) begin
            chk("idle_psel", 32'(PSEL), 32'd0);
            chk("idle_penable", 32'(PENABLE), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(ready), 32'd0);
            chk("idle_err", 32'(err), 32'd0);
            chk("idle_rdata", rdata, 32'd0);
        end else begin
            d      = cyc - t0;
            e_end  = 2 + eff_wait();
            e_psel = (d >= 1 && m_slv >= 0) ? 5'(1 << m_slv) : 5'd0;
            e_rdy  = (d == e_end);
            e_err  = e_rdy && (m_slv < 0 || timed_out());
            e_rd   = '0;
            if (e_rdy && !e_err) e_rd = sd[m_slv];
            chk("busy", 32'(busy), 32'(d >= 1));
            chk("psel", 32'(PSEL), 32'(e_psel));
            chk("penable", 32'(PENABLE), 32'(d >= 2));
            chk("ready", 32'(ready), 32'(e_rdy));
            chk("err", 32'(err), 32'(e_err));
            chk("rdata", rdata, e_rd);
            if (d >= 1) begin
                chk("paddr", PADDR, m_addr);
                chk("pwdata", PWDATA, m_wdata);
                chk("pwrite", 32'(PWRITE), 32'(m_write));
            end
        end
        if (ready === 1'b1) begin
            n_ready++;
            r_cyc = cyc; r_psel = PSEL; r_err = err; r_rdata = rdata;
            r_paddr = PADDR; r_pwdata = PWDATA;
        end
    end

    // Called just after a rising edge; returns just after a rising edge with the bench idle.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int wt, input bit glitch, input int abort_at);
        transfer = 1'b1; addr = a; write = w; wdata = wd;
        m_addr = a; m_write = w; m_wdata = wd; m_wait = wt; m_slv = slave_of(a);
        t0 = cyc; act = 1;
        @(posedge PCLK); #1;
        addr = a ^ 32'h0000_3004; wdata = ~wd; write = ~w;
        transfer = glitch;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        while (cyc < t0 + 3 + eff_wait()) begin
            if (abort_at >= 0 && cyc == t0 + abort_at) begin
                #1;
                PRESET = 1'b1; act = 0; m_slv = -1;
                #1;
                chk("abort_psel", 32'(PSEL), 32'd0);
                chk("abort_penable", 32'(PENABLE), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_ready", 32'(ready), 32'd0);
                @(posedge PCLK); #1;
                PRESET = 1'b0;
                return;
            end
            @(posedge PCLK); #1;
        end
        act = 0; m_slv = -1;
    endtask

    initial begin : stim
        int nr;
        for (int i = 0; i < 5; i++) sd[i] = 32'hBAD0_0000 | 32'(i);
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // FND write, PREADY one cycle after first PENABLE
        nr = n_ready;
        xfer(32'h1000_4000, 1'b1, 32'h0000_04D2, 1, 1'b0, -1);
        chk("fnd_count", 32'(n_ready - nr), 32'd1);
        chk("fnd_lat", 32'(r_cyc - t0), 32'd3);
        chk("fnd_psel", 32'(r_psel), 32'b10000);
        chk("fnd_pwdata", r_pwdata, 32'h0000_04D2);
        chk("fnd_err", 32'(r_err), 32'd0);

        // RAM read, immediate PREADY; next request right at T+3
        sd[0] = 32'hCAFE_F00D;
        xfer(32'h1000_0008, 1'b0, 32'h1111_2222, 0, 1'b0, -1);
        chk("ram_lat", 32'(r_cyc - t0), 32'd2);
        chk("ram_rdata", r_rdata, 32'hCAFE_F00D);
        chk("ram_psel", 32'(r_psel), 32'b00001);

        // Unmapped read
        xfer(32'h2000_0000, 1'b0, 32'h0, 0, 1'b0, -1);
        chk("unm_lat", 32'(r_cyc - t0), 32'd2);
        chk("unm_err", 32'(r_err), 32'd1);
        chk("unm_rdata", r_rdata, 32'd0);
        chk("unm_psel", 32'(r_psel), 32'd0);

        // Transfer pulsed again during SETUP with another address
        nr = n_ready;
        xfer(32'h1000_1010, 1'b1, 32'hA5A5_5A5A, 2, 1'b1, -1);
        chk("glitch_count", 32'(n_ready - nr), 32'd1);
        chk("glitch_paddr", r_paddr, 32'h1000_1010);

        // Back-to-back GPIO then GPI reads
        sd[3] = 32'h0000_3C3C;
        sd[2] = 32'h8765_4321;
        xfer(32'h1000_3FFC, 1'b0, 32'h0, 3, 1'b0, -1);
        chk("gpio_rdata", r_rdata, 32'h0000_3C3C);
        xfer(32'h1000_2004, 1'b0, 32'h0, 0, 1'b0, -1);
        chk("gpi_rdata", r_rdata, 32'h8765_4321);

        // Reset asserted mid-ACCESS
        nr = n_ready;
        xfer(32'h1000_0000, 1'b0, 32'h0, 10, 1'b0, 3);
        chk("abort_noready", 32'(n_ready - nr), 32'd0);
        @(posedge PCLK); #1;

        // GPI never ready
        nr = n_ready;
        xfer(32'h1000_2000, 1'b0, 32'h0, 1000, 1'b0, 302);
`ifdef APB_MASTER_TIMEOUT_EN
        chk("tmo_count", 32'(n_ready - nr), 32'd1);
        chk("tmo_lat", 32'(r_cyc - t0), 32'(2 + TMO));
        chk("tmo_err", 32'(r_err), 32'd1);
        chk("tmo_rdata", r_rdata, 32'd0);
`else
        chk("hang_noready", 32'(n_ready - nr), 32'd0);
`endif

        // Recovery after the abandoned transfer
        xfer(32'h1000_4010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, -1);
        chk("rec_pwdata", r_pwdata, 32'hDEAD_BEEF);

        repeat (2) @(posedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
